// File: rtl/dshot_arm_sequencer_pkg.sv
// ============================================================================
// Module : dshot_pkg
// Desc   : Shared state encoding, DShot constants and throttle mapping helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dshot_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        FAILSAFE = 2'd2
    } dshot_state_t;

    localparam int DSHOT_CMD_MAX   = 47;
    localparam int THROTTLE_OFFSET = 48;
    localparam int THROTTLE_MAX    = 1999;
    localparam int BEEP_CMD_LAST   = 5;

    // Raw values below the offset are commands and carry no throttle.
    function automatic logic [10:0] throttleFromSpeed(input logic [10:0] speed);
        logic [10:0] scaled;
        if (speed < 11'(THROTTLE_OFFSET)) begin
            scaled = 11'd0;
        end else begin
            scaled = speed - 11'(THROTTLE_OFFSET);
        end
        if (scaled > 11'(THROTTLE_MAX)) begin
            scaled = 11'(THROTTLE_MAX);
        end
        return scaled;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dshot_arm_sequencer_if.sv
// ============================================================================
// Module : dshot_arm_sequencer_if
// Desc   : Decoded-frame bundle from the DShot frame decoder to the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dshot_arm_sequencer_if;

    logic        frameDone;
    logic [10:0] setSpeed;
    logic        isSpecialCommand;
    logic [5:0]  specialCommand;
    logic        CRCValid;
    logic        telemetryBit;

    modport master (
        output frameDone,
        output setSpeed,
        output isSpecialCommand,
        output specialCommand,
        output CRCValid,
        output telemetryBit
    );

    modport slave (
        input frameDone,
        input setSpeed,
        input isSpecialCommand,
        input specialCommand,
        input CRCValid,
        input telemetryBit
    );

endinterface

`default_nettype wire

// File: rtl/dshot_arm_sequencer_repeat_filter.sv
// ============================================================================
// Module : dshot_repeat_filter
// Desc   : Counts consecutive identical commands and flags the single frame
//          that completes the required repeat run.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dshot_repeat_filter #(
    parameter int CMD_REPEAT = 6
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       valid,
    input  wire logic       clear,
    input  wire logic       isCmd,
    input  wire logic [5:0] code,
    output logic            fire
);

    localparam int RW = $clog2(CMD_REPEAT + 1);
    localparam logic [RW-1:0] c_REP_MAX = RW'(CMD_REPEAT);
    localparam logic [RW-1:0] c_REP_ONE = RW'(1);

    logic [RW-1:0] r_repCnt;
    logic [5:0]    r_lastCode;
    logic          w_same;
    logic [RW-1:0] w_nextCnt;

    always_comb begin
        w_same = isCmd && (r_repCnt != '0) && (code == r_lastCode);
        if (!isCmd) begin
            w_nextCnt = '0;
        end else if (!w_same) begin
            w_nextCnt = c_REP_ONE;
        end else if (r_repCnt == c_REP_MAX) begin
            w_nextCnt = c_REP_MAX;
        end else begin
            w_nextCnt = r_repCnt + c_REP_ONE;
        end
        // A run already sitting at saturation must not fire again.
        fire = valid && isCmd && (w_nextCnt == c_REP_MAX) &&
               !(w_same && (r_repCnt == c_REP_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_repCnt   <= '0;
            r_lastCode <= '0;
        end else if (valid) begin
            r_repCnt   <= w_nextCnt;
            r_lastCode <= code;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dshot_arm_sequencer.sv
// ============================================================================
// Module : dshot_arm_sequencer
// Desc   : Arming / failsafe / special-command policy behind the DShot decoder.
//          Optional CRC error counter enabled by DSHOT_ERRCNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dshot_arm_sequencer
    import dshot_pkg::*;
#(
    parameter int ARM_FRAMES     = 10,
    parameter int CMD_REPEAT     = 6,
    parameter int TIMEOUT_CYCLES = 1_600_000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    dshot_arm_sequencer_if.slave   frame,
    output logic [10:0]            throttle,
    output logic                   armed,
    output logic                   failsafe,
    output logic                   cmdStrobe,
    output logic [5:0]             cmdCode,
    output logic                   telemetryReq
`ifdef DSHOT_ERRCNT_EN
    ,
    output logic [7:0]             crcErrors
`endif
);

    localparam int ZW = $clog2(ARM_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ZW-1:0] c_ARM_LAST = ZW'(ARM_FRAMES - 1);
    localparam logic [ZW-1:0] c_ZERO_ONE = ZW'(1);
    localparam logic [TW-1:0] c_TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] c_TO_ONE   = TW'(1);

    dshot_state_t  r_state;
    logic [ZW-1:0] r_zeroCnt;
    logic [TW-1:0] r_toCnt;

    logic w_valid;
    logic w_isZero;
    logic w_toExpired;
    logic w_beep;
    logic w_repIsCmd;
    logic w_repValid;
    logic w_repClear;
    logic w_fire;

    always_comb begin
        w_valid     = frame.frameDone && frame.CRCValid;
        w_isZero    = (frame.setSpeed == 11'd0);
        w_toExpired = (r_toCnt == c_TO_LAST);
        w_beep      = frame.isSpecialCommand && (frame.specialCommand != 6'd0) &&
                      (frame.specialCommand <= 6'(BEEP_CMD_LAST));
        w_repIsCmd  = frame.isSpecialCommand &&
                      (frame.specialCommand > 6'(BEEP_CMD_LAST)) &&
                      (frame.specialCommand <= 6'(DSHOT_CMD_MAX));
        w_repValid  = w_valid && (r_state == ARMED);
        w_repClear  = !w_valid && w_toExpired && (r_state == ARMED);
    end

    dshot_repeat_filter #(
        .CMD_REPEAT (CMD_REPEAT)
    ) u_repeat_filter (
        .clk   (clk),
        .rst   (rst),
        .valid (w_repValid),
        .clear (w_repClear),
        .isCmd (w_repIsCmd),
        .code  (frame.specialCommand),
        .fire  (w_fire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= DISARMED;
            r_zeroCnt    <= '0;
            r_toCnt      <= '0;
            throttle     <= '0;
            armed        <= 1'b0;
            failsafe     <= 1'b0;
            cmdStrobe    <= 1'b0;
            cmdCode      <= '0;
            telemetryReq <= 1'b0;
        end else begin
            cmdStrobe    <= 1'b0;
            telemetryReq <= w_valid && frame.telemetryBit;
            case (r_state)
                DISARMED: begin
                    if (w_valid) begin
                        r_toCnt <= '0;
                        if (w_isZero && (r_zeroCnt == c_ARM_LAST)) begin
                            r_state   <= ARMED;
                            armed     <= 1'b1;
                            r_zeroCnt <= '0;
                        end else if (w_isZero) begin
                            r_zeroCnt <= r_zeroCnt + c_ZERO_ONE;
                        end else begin
                            r_zeroCnt <= '0;
                        end
                    end else if (w_toExpired) begin
                        r_state   <= FAILSAFE;
                        failsafe  <= 1'b1;
                        throttle  <= '0;
                        r_zeroCnt <= '0;
                        r_toCnt   <= '0;
                    end else begin
                        r_toCnt <= r_toCnt + c_TO_ONE;
                    end
                end

                ARMED: begin
                    if (w_valid) begin
                        r_toCnt  <= '0;
                        throttle <= throttleFromSpeed(frame.setSpeed);
                        if (w_beep || w_fire) begin
                            cmdStrobe <= 1'b1;
                            cmdCode   <= frame.specialCommand;
                        end
                    end else if (w_toExpired) begin
                        r_state   <= FAILSAFE;
                        armed     <= 1'b0;
                        failsafe  <= 1'b1;
                        throttle  <= '0;
                        r_zeroCnt <= '0;
                        r_toCnt   <= '0;
                    end else begin
                        r_toCnt <= r_toCnt + c_TO_ONE;
                    end
                end

                FAILSAFE: begin
                    // The recovering frame already counts towards re-arming.
                    if (w_valid) begin
                        r_state   <= DISARMED;
                        failsafe  <= 1'b0;
                        r_zeroCnt <= w_isZero ? c_ZERO_ONE : '0;
                        r_toCnt   <= '0;
                    end
                end

                default: begin
                    r_state   <= DISARMED;
                    armed     <= 1'b0;
                    failsafe  <= 1'b0;
                    throttle  <= '0;
                    r_zeroCnt <= '0;
                    r_toCnt   <= '0;
                end
            endcase
        end
    end

`ifdef DSHOT_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            crcErrors <= '0;
        end else if (frame.frameDone && !frame.CRCValid && (crcErrors != 8'hFF)) begin
            crcErrors <= crcErrors + 8'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/dshot_arm_sequencer.md
# dshot_arm_sequencer

Control stage behind the DShot frame decoder (`dshotInput`). Consumes decoded frames and owns the arming, failsafe and special-command policy. Drives a gated throttle value, 0..1999, to the motor output stage and emits qualified one-cycle command strobes. Invalid-CRC frames never reach the motor.

## Interface
Parameters:
- ARM_FRAMES, 10, consecutive valid zero-command frames required to arm
- CMD_REPEAT, 6, consecutive identical frames required for commands 6..47
- TIMEOUT_CYCLES, 1_600_000, clocks without a valid frame before failsafe (100 ms at 16 MHz)

Ports:
- clk  in  1  system clock (16 MHz); all logic on rising edge
- rst  in  1  synchronous, active-high reset
- frameDone  in  1  one-cycle strobe from the decoder; the other decoder inputs are stable on this cycle
- setSpeed  in  11  raw 11-bit DShot value
- isSpecialCommand  in  1  high when setSpeed < 48
- specialCommand  in  6  setSpeed[5:0]
- CRCValid  in  1  frame checksum correct
- telemetryBit  in  1  frame telemetry request bit
- throttle  out  11  gated throttle, 0..1999
- armed  out  1  high in state ARMED
- failsafe  out  1  high in state FAILSAFE
- cmdStrobe  out  1  one-cycle pulse; a special command has been accepted
- cmdCode  out  6  accepted command code; valid when cmdStrobe is high
- telemetryReq  out  1  one-cycle pulse; a valid frame had telemetryBit set

## Operation
A frame is valid when frameDone && CRCValid. All other frameDone cycles are ignored entirely: they change no state and no counters, and do not reload the timeout.

States:
- DISARMED
  - throttle = 0.
  - A valid setSpeed == 0 frame increments zeroCnt.
  - Any other valid frame clears zeroCnt.
  - When zeroCnt reaches ARM_FRAMES, go to ARMED and clear zeroCnt.
- ARMED
  - Valid frame with setSpeed ≥ 48: throttle = setSpeed − 48.
  - Valid frame with setSpeed < 48: throttle = 0, then the command rules below apply.
- FAILSAFE
  - throttle = 0, armed = 0.
  - The next valid frame moves to DISARMED. If that frame has setSpeed == 0, it counts as zeroCnt = 1.

Command rules (ARMED only; commands are never executed in DISARMED or FAILSAFE):
- Code 0: stop only; no strobe.
- Codes 1..5: one strobe per valid frame.
- Codes 6..47:
  - repCnt counts consecutive valid frames carrying the same code.
  - A strobe fires on the frame that brings repCnt to CMD_REPEAT, once only.
  - Further identical frames produce no strobe.
  - repCnt saturates at CMD_REPEAT.
  - Any different valid frame, including a throttle frame, reloads repCnt to 1 for a new code 6..47, or 0 otherwise.

Timeout:
- toCnt clears on every valid frame and increments otherwise. It is active in DISARMED and ARMED only.
- When toCnt reaches TIMEOUT_CYCLES − 1, go to FAILSAFE and clear zeroCnt and repCnt.

Telemetry:
- telemetryReq pulses for every valid frame with telemetryBit = 1, in every state.

## Timing
- Reset values: throttle 0, armed 0, failsafe 0, cmdStrobe 0, cmdCode 0, telemetryReq 0; state DISARMED; all counters 0.
- All outputs are registered.
- Latency: a frame on frameDone cycle N updates the outputs on cycle N+1.
- The arming frame updates armed at N+1. throttle stays 0 on that frame.
- Timeout terminal count and a valid frame on the same cycle: the frame wins. The counter clears and the state does not change.
- cmdStrobe and telemetryReq may assert on the same cycle.
- rst asserted mid-frame or mid-repeat abandons everything. The next cycle shows reset values.
- throttle is held between frames. It changes only on valid frames or on entry to FAILSAFE.

## Configuration
- DSHOT_ERRCNT_EN defined:
  - Adds the output crcErrors [7:0], reset 0.
  - It increments on each frameDone && !CRCValid and saturates at 255.
  - It clears only on rst.
- DSHOT_ERRCNT_EN undefined: the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- Package dshot_pkg:
  - State enum: DISARMED, ARMED, FAILSAFE.
  - DSHOT_CMD_MAX = 47, THROTTLE_OFFSET = 48, THROTTLE_MAX = 1999.
  - BEEP_CMD_LAST = 5.
- Sub-module dshot_repeat_filter:
  - Owns repCnt and the once-only strobe.
  - Inputs: valid, code, isCmd.
  - Output: fire.

## Test plan
Bench parameters: ARM_FRAMES=3, CMD_REPEAT=6, TIMEOUT_CYCLES=1000.
- Arming:
  - Stimulus: three valid setSpeed=0 frames, then setSpeed=1048.
  - Response: armed=1 one cycle after the third frame; throttle=1000 one cycle after the fourth.
- Arming interrupted:
  - Stimulus: 0, 0, 500, 0, 0 (all valid).
  - Response: armed stays 0.
- Bad CRC:
  - Stimulus: armed, valid setSpeed=1048, then a CRCValid=0 frame with setSpeed=2047.
  - Response: throttle stays 1000; crcErrors=1 when DSHOT_ERRCNT_EN is defined.
- Repeated command:
  - Stimulus: armed, eight valid code-7 frames.
  - Response: exactly one cmdStrobe with cmdCode=7, one cycle after the 6th frame. A code-7 frame, then 1048, then five more code-7 frames: no strobe.
- Failsafe:
  - Stimulus: armed with throttle=1000, then no frames for 1000 cycles.
  - Response: failsafe=1, throttle=0, armed=0. The next valid setSpeed=0 frame gives failsafe=0 and zeroCnt=1; two more arm the block.
- Beep and telemetry:
  - Stimulus: armed, one valid code-3 frame with telemetryBit=1.
  - Response: cmdStrobe, cmdCode=3 and telemetryReq all on the same cycle. The same frame in DISARMED gives telemetryReq only.
